// File: rtl/adc_dma_packetizer_if.sv
// AXI-Stream style bundle used for the packetizer's input and output ports.
// Signals: tdata, tvalid, tready, tlast; master drives data, slave drives ready.
interface adc_dma_packetizer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/adc_dma_packetizer.sv
// Cuts the ADC readout stream into fixed-length packets with TLAST, padding
// with zero words on a mid-packet disable. Optional header beat carrying
// {seq, len} is compiled in when ADC_PKT_HEADER_EN is defined.
// Ports: clk, rst (async, active-low), enable, pkt_len, s_axis (slave),
//        m_axis (master), pkt_count (TLAST handshakes), pad_count (padded pkts).
module adc_dma_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    adc_dma_packetizer_if.slave  s_axis,
    adc_dma_packetizer_if.master m_axis,
    output logic [31:0]          pkt_count,
    output logic [15:0]          pad_count
);

`ifdef ADC_PKT_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, PAD = 2'd3} state_t;
    logic [LEN_WIDTH-1:0] seq_q, seq_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2, PAD = 2'd3} state_t;
`endif

    localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, sk_data_q;
    logic                  out_valid_q, out_last_q;
    logic                  sk_valid_q, sk_last_q;
    logic [31:0]           pkt_cnt_q;
    logic [15:0]           pad_cnt_q;

    logic                  push, push_last, s_ready, pad_inc;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  free, pop, beat_last;

    // A push is only allowed while the skid slot is empty, so the two
    // entries can never overflow.
    assign free      = !sk_valid_q;
    assign pop       = out_valid_q && m_axis.tready;
    assign beat_last = (cnt_q == len_q - ONE);

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;
    assign pkt_count     = pkt_cnt_q;
    assign pad_count     = pad_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = '0;
        push_last = 1'b0;
        s_ready   = 1'b0;
        pad_inc   = 1'b0;
`ifdef ADC_PKT_HEADER_EN
        seq_d     = seq_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    len_d = (pkt_len == '0) ? ONE : pkt_len;
                    cnt_d = '0;
`ifdef ADC_PKT_HEADER_EN
                    state_d = HDR;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef ADC_PKT_HEADER_EN
            HDR: begin
                if (free) begin
                    push      = 1'b1;
                    push_data = {{(DATA_WIDTH-2*LEN_WIDTH){1'b0}}, seq_q, len_q};
                    seq_d     = seq_q + ONE;
                    state_d   = DATA;
                end
            end
`endif
            DATA: begin
                s_ready = free;
                if (s_axis.tvalid && free) begin
                    push      = 1'b1;
                    push_data = s_axis.tdata;
                    push_last = beat_last;
                    cnt_d     = cnt_q + ONE;
                    // A final beat taken with enable low still closes normally.
                    if (beat_last)    state_d = IDLE;
                    else if (!enable) state_d = PAD;
                end else if (!enable) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (free) begin
                    push      = 1'b1;
                    push_last = beat_last;
                    cnt_d     = cnt_q + ONE;
                    if (beat_last) begin
                        pad_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= ONE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sk_data_q   <= '0;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            pad_cnt_q   <= '0;
`ifdef ADC_PKT_HEADER_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef ADC_PKT_HEADER_EN
            seq_q   <= seq_d;
`endif
            // Output register refills from the skid slot first to keep order.
            if (!out_valid_q || pop) begin
                if (sk_valid_q) begin
                    out_data_q  <= sk_data_q;
                    out_last_q  <= sk_last_q;
                    out_valid_q <= 1'b1;
                    sk_valid_q  <= 1'b0;
                end else begin
                    out_valid_q <= push;
                    out_last_q  <= push && push_last;
                    if (push) out_data_q <= push_data;
                end
            end else if (push) begin
                sk_data_q  <= push_data;
                sk_last_q  <= push_last;
                sk_valid_q <= 1'b1;
            end
            if (pop && out_last_q)
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (pad_inc && pad_cnt_q != 16'hFFFF)
                pad_cnt_q <= pad_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_dma_packetizer.sv
// Scoreboard bench for adc_dma_packetizer: directed packets, padding,
// output back-pressure, zero length and mid-packet reset.
module tb_adc_dma_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pkt_len = 16'd4;
    logic [31:0] pkt_count;
    logic [15:0] pad_count;

    adc_dma_packetizer_if #(.DW(32)) s_if ();
    adc_dma_packetizer_if #(.DW(32)) m_if ();

    adc_dma_packetizer dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pkt_len   (pkt_len),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_count (pkt_count),
        .pad_count (pad_count)
    );

    initial forever #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];
    logic [15:0] exp_seq = 16'd0;
    bit          tog_en = 1'b0;
    logic        rdy_lvl = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic exp_hdr(input logic [15:0] len);
`ifdef ADC_PKT_HEADER_EN
        exp_q.push_back({1'b0, exp_seq, len});
        exp_seq++;
`else
        if (len == 16'd0) exp_seq = exp_seq;
`endif
    endtask

    task automatic monitor();
        logic        stall;
        logic [31:0] pd;
        logic        pl;
        logic [32:0] e;
        stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 32'(m_if.tvalid), 32'd1);
                    chk("hold_data", m_if.tdata, pd);
                    chk("hold_last", 32'(m_if.tlast), 32'(pl));
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got %h last %b required none",
                                 m_if.tdata, m_if.tlast);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_if.tdata, e[31:0]);
                        chk("beat_last", 32'(m_if.tlast), 32'(e[32]));
                    end
                end
                stall = m_if.tvalid && !m_if.tready;
                pd    = m_if.tdata;
                pl    = m_if.tlast;
            end
        end
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = tog_en ? !m_if.tready : rdy_lvl;
        end
    endtask

    // Presents n consecutive words; optionally drops enable right after
    // the edge on which the n-th word is accepted.
    task automatic send(input int n, input logic [31:0] first, input bit drop);
        bit hs;
        int g;
        for (int i = 0; i < n; i++) begin
            s_if.tdata  = first + 32'(i);
            s_if.tvalid = 1'b1;
            g = 0;
            hs = 1'b0;
            while (!hs && g < 200) begin
                @(negedge clk);
                hs = s_if.tready;
                @(posedge clk);
                #1;
                g++;
            end
            if (!hs) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: word %0d got no tready required accept", i);
            end
        end
        if (drop) enable = 1'b0;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        fork
            monitor();
            rdy_drv();
        join_none

        // reset state
        #12;
        chk("rst_m_valid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_last", 32'(m_if.tlast), 32'd0);
        chk("rst_m_data", m_if.tdata, 32'd0);
        chk("rst_s_ready", 32'(s_if.tready), 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_pad", 32'(pad_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // two back-to-back packets of 4
        @(posedge clk);
        #1;
        pkt_len = 16'd4;
        enable  = 1'b1;
        exp_hdr(16'd4);
        for (int i = 1; i <= 4; i++) exp_beat(32'(i), i == 4);
        exp_hdr(16'd4);
        for (int i = 5; i <= 8; i++) exp_beat(32'(i), i == 8);
        send(8, 32'd1, 1'b1);
        drain();
        chk("t1_pkt", pkt_count, 32'd2);
        chk("t1_pad", 32'(pad_count), 32'd0);

        // disable after 3 of 8 beats -> zero padding
        pkt_len = 16'd8;
        enable  = 1'b1;
        exp_hdr(16'd8);
        exp_beat(32'h0000_000A, 1'b0);
        exp_beat(32'h0000_000B, 1'b0);
        exp_beat(32'h0000_000C, 1'b0);
        for (int i = 0; i < 5; i++) exp_beat(32'd0, i == 4);
        send(3, 32'h0000_000A, 1'b1);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("t2_s_ready", 32'(s_if.tready), 32'd0);
        end
        drain();
        chk("t2_pad", 32'(pad_count), 32'd1);
        chk("t2_pkt", pkt_count, 32'd3);

        // output back-pressure 1010...
        tog_en  = 1'b1;
        pkt_len = 16'd4;
        enable  = 1'b1;
        exp_hdr(16'd4);
        for (int i = 0; i < 4; i++) exp_beat(32'h30 + 32'(i), i == 3);
        exp_hdr(16'd4);
        for (int i = 4; i < 8; i++) exp_beat(32'h30 + 32'(i), i == 7);
        send(8, 32'h30, 1'b1);
        drain();
        tog_en  = 1'b0;
        rdy_lvl = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_pkt", pkt_count, 32'd5);

        // zero length behaves as one beat per packet
        pkt_len = 16'd0;
        enable  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_hdr(16'd1);
            exp_beat(32'h60 + 32'(i), 1'b1);
        end
        send(3, 32'h60, 1'b1);
        drain();
        chk("t4_pkt", pkt_count, 32'd8);
        chk("t4_pad", 32'(pad_count), 32'd1);

        // reset mid-packet after 2 of 4 accepted
        @(posedge clk);
        #1;
        pkt_len = 16'd4;
        enable  = 1'b1;
        exp_hdr(16'd4);
        exp_beat(32'h50, 1'b0);
        send(2, 32'h50, 1'b0);
        #1;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_m_valid", 32'(m_if.tvalid), 32'd0);
        chk("mid_m_last", 32'(m_if.tlast), 32'd0);
        chk("mid_m_data", m_if.tdata, 32'd0);
        chk("mid_s_ready", 32'(s_if.tready), 32'd0);
        chk("mid_pkt", pkt_count, 32'd0);
        chk("mid_pad", 32'(pad_count), 32'd0);
        chk("mid_sb", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_seq = 16'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        exp_hdr(16'd4);
        for (int i = 0; i < 4; i++) exp_beat(32'h70 + 32'(i), i == 3);
        send(4, 32'h70, 1'b1);
        drain();
        chk("t5_pkt", pkt_count, 32'd1);
        chk("t5_pad", 32'(pad_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
